sha256_chunk_engine: RTL

//  Iterative SHA-256 compression engine: accepts one 512-bit chunk per transaction and runs
//  64 rounds at ROUNDS_PER_CYCLE rounds/clk. Adds the feed-forward into the chaining value
//  and chains across multi-chunk messages. Successor to the fully unrolled combinational

---
 rtl/sha256_chunk_engine_if.sv | 33 +++
 rtl/sha256_chunk_engine.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sha256_chunk_engine_if.sv
// sha256_chunk_engine_if: chunk-in / digest-out handshake bundle for sha256_chunk_engine.
// The in_mode224 signal exists only when SHA256_SHA224_EN is defined.
interface sha256_chunk_engine_if;
   logic         in_valid;
   logic         in_ready;
   logic         in_first;
   logic [511:0] in_chunk;
   logic         out_valid;
   logic         out_ready;
   logic [255:0] out_digest;
   logic         busy;
`ifdef SHA256_SHA224_EN
   logic         in_mode224;
`endif

   // Host side: offers chunks, consumes digests.
   modport master (
`ifdef SHA256_SHA224_EN
      output in_mode224,
`endif
      output in_valid, in_first, in_chunk, out_ready,
      input  in_ready, out_valid, out_digest, busy
   );

   // Engine side.
   modport slave (
`ifdef SHA256_SHA224_EN
      input  in_mode224,
`endif
      input  in_valid, in_first, in_chunk, out_ready,
      output in_ready, out_valid, out_digest, busy
   );
endinterface

// File: rtl/sha256_chunk_engine.sv
// sha256_chunk_engine: iterative SHA-256 compression of one pre-padded 512-bit chunk,
// ROUNDS_PER_CYCLE rounds per clock, with feed-forward and multi-chunk chaining.
// Optional feature macro: SHA256_SHA224_EN (adds in_mode224 and the SHA-224 IV/truncation).
module sha256_chunk_engine #(
   parameter int CHUNKSIZE        = 512,
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input logic                  clk,
   input logic                  reset,
   sha256_chunk_engine_if.slave bus
);
   localparam int R = ROUNDS_PER_CYCLE;

   // H0 sits in the least significant word throughout.
   localparam logic [255:0] IV256 = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                     32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   generate
      if (CHUNKSIZE != 512) begin : g_bad_chunksize
         $error("sha256_chunk_engine: CHUNKSIZE must be 512");
      end
      if (R != 1 && R != 2 && R != 4 && R != 8 && R != 16) begin : g_bad_rounds
         $error("sha256_chunk_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction
   function automatic logic [31:0] big_s0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction
   function automatic logic [31:0] big_s1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction
   function automatic logic [31:0] small_s0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] small_s1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;
   state_t state_reg, state_next;

   logic [255:0] work_reg;     // a..h, a in word 0
   logic [511:0] win_reg;      // W[t..t+15], W[t] in word 0
   logic [255:0] chain_reg;    // chaining value the current chunk started from
   logic [255:0] digest_reg;
   logic [5:0]   cnt_reg;
   logic [255:0] start_h;
   logic [255:0] chain_sum;
   logic [255:0] round_st;
   logic [511:0] round_win;
   logic         accept;
   logic         in_ready_c, out_valid_c, busy_c;

   assign accept = (state_reg == S_IDLE) && bus.in_valid;

   // R rounds chained combinationally; each stage consumes W[t] and slides the window by one.
   genvar gi;
   generate
      for (gi = 0; gi < R; gi++) begin : g_round
         logic [255:0] st_in, st_out;
         logic [511:0] win_in, win_out;
         logic [5:0]   t_idx;
         logic [31:0]  a, b, c, d, e, f, g, h, t1, t2, w_new;
         if (gi == 0) begin : g_head
            assign st_in  = work_reg;
            assign win_in = win_reg;
         end else begin : g_link
            assign st_in  = g_round[gi-1].st_out;
            assign win_in = g_round[gi-1].win_out;
         end
         assign t_idx = cnt_reg + 6'(gi);
         assign {h, g, f, e, d, c, b, a} = st_in;
         assign t1      = h + big_s1(e) + ((e & f) ^ (~e & g)) + K[t_idx] + win_in[31:0];
         assign t2      = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
         assign st_out  = {g, f, e, d + t1, c, b, a, t1 + t2};
         assign w_new   = win_in[31:0] + small_s0(win_in[63:32]) + win_in[32*9 +: 32]
                        + small_s1(win_in[32*14 +: 32]);
         assign win_out = {w_new, win_in[511:32]};
      end
      for (gi = 0; gi < 8; gi++) begin : g_ff
         assign chain_sum[32*gi +: 32] = chain_reg[32*gi +: 32] + work_reg[32*gi +: 32];
      end
   endgenerate

   assign round_st  = g_round[R-1].st_out;
   assign round_win = g_round[R-1].win_out;

`ifdef SHA256_SHA224_EN
   localparam logic [255:0] IV224 = {32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
                                     32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8};
   logic mode224_reg;

   assign start_h = bus.in_first ? (bus.in_mode224 ? IV224 : IV256) : chain_reg;

   // Mode is captured with in_first and persists across chained chunks.
   always_ff @(posedge clk) begin
      if (reset)
         mode224_reg <= 1'b0;
      else if (accept && bus.in_first)
         mode224_reg <= bus.in_mode224;
   end

   assign bus.out_digest = (state_reg == S_DONE && mode224_reg) ? {32'h0, digest_reg[223:0]}
                                                                 : digest_reg;
`else
   assign start_h        = bus.in_first ? IV256 : chain_reg;
   assign bus.out_digest = digest_reg;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (bus.in_valid) state_next = S_ROUND;
         S_ROUND: if (cnt_reg == 6'(64 - R)) state_next = S_FINAL;
         S_FINAL: state_next = S_DONE;
         S_DONE:  if (bus.out_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      busy_c      = 1'b0;
      case (state_reg)
         S_IDLE:  in_ready_c  = 1'b1;
         S_ROUND: busy_c      = 1'b1;
         S_FINAL: busy_c      = 1'b1;
         S_DONE:  out_valid_c = 1'b1;
         default: in_ready_c  = 1'b0;
      endcase
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.busy      = busy_c;

   // Datapath: load on accept, iterate rounds, fold in the feed-forward at the end.
   always_ff @(posedge clk) begin
      if (reset) begin
         work_reg   <= '0;
         win_reg    <= '0;
         chain_reg  <= IV256;
         digest_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         case (state_reg)
            S_IDLE: if (accept) begin
               win_reg   <= bus.in_chunk;
               work_reg  <= start_h;
               chain_reg <= start_h;
               cnt_reg   <= '0;
            end
            S_ROUND: begin
               work_reg <= round_st;
               win_reg  <= round_win;
               cnt_reg  <= cnt_reg + 6'(R);
            end
            S_FINAL: begin
               chain_reg  <= chain_sum;
               digest_reg <= chain_sum;
            end
            default: ;
         endcase
      end
   end
endmodule
